// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches words over req/ack into a prefetch queue and hands them to the core with their PC
module instruction_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_ins_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_ins_pc,
    input  logic        i_ins_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] W_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t        r_state, w_state_next;
    logic          r_req, w_req_next;
    logic [31:0]   r_addr, w_addr_next;
    logic [31:0]   r_fetch_pc, w_fetch_pc_next;
    logic [31:0]   r_q_ins [DEPTH];
    logic [31:0]   r_q_pc [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0]   r_count, w_count_next;
    logic          w_ack, w_push, w_pop, w_space;
    logic [31:0]   w_redirect_pc;

    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};
    assign w_ack         = i_imem_ack && r_req;
    assign w_push        = w_ack && r_state == WAIT && !i_redirect;
    assign w_pop         = o_ins_valid && i_ins_ready && !i_redirect;
    assign w_count_next  = i_redirect ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_space       = w_count_next < W_DEPTH;

    assign o_imem_req    = r_req;
    assign o_imem_addr   = r_addr;
    assign o_ins_valid   = r_count != '0;
    assign o_instruction = o_ins_valid ? r_q_ins[r_rd] : '0;
    assign o_ins_pc      = o_ins_valid ? r_q_pc[r_rd] : '0;

    // Next-state: redirect wins; a fresh request starts from idle or right after an ack when the queue has room
    always_comb begin
        w_state_next    = r_state;
        w_req_next      = r_req;
        w_addr_next     = r_addr;
        w_fetch_pc_next = w_push ? r_fetch_pc + 32'd4 : r_fetch_pc;
        if (i_redirect) begin
            w_fetch_pc_next = w_redirect_pc;
            if (r_state == IDLE || w_ack) begin
                w_state_next = WAIT;
                w_req_next   = 1'b1;
                w_addr_next  = w_redirect_pc;
            end else begin
                w_state_next = DISCARD;
            end
        end else if (r_state == IDLE || w_ack) begin
            w_state_next = w_space ? WAIT : IDLE;
            w_req_next   = w_space;
            w_addr_next  = w_space ? w_fetch_pc_next : r_addr;
        end
    end

    // Fetch state, request and next fetch address registers
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_req      <= w_req_next;
            r_addr     <= w_addr_next;
            r_fetch_pc <= w_fetch_pc_next;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_redirect) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
        end
    end

    // Queue storage holds each kept word with the address it was fetched from
    always_ff @(posedge i_clk) begin
        if (i_reset && w_push) begin
            r_q_ins[r_wr] <= i_imem_rdata;
            r_q_pc[r_wr]  <= r_addr;
        end
    end
endmodule
